// File: rtl/hdr_pkg.sv
// Shared types and sizes for the comp_unit header read path.
package hdr_pkg;

  localparam int unsigned HDR_AW    = 4;
  localparam int unsigned HDR_DW    = 32;
  localparam int unsigned HDR_DEPTH = 1 << HDR_AW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } hdr_state_e;

endpackage

// File: rtl/hdr_out_stage.sv
// Single-entry registered output stage with valid/ready handshake and last flag.
module hdr_out_stage #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready_c,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          load;

  // The slot is free when empty or when its word leaves this cycle.
  assign in_ready_c = !valid_q || m_ready;
  assign load       = in_valid && in_ready_c;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      data_d  = in_data;
      valid_d = 1'b1;
      last_d  = in_last;
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign m_data  = data_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;

endmodule

// File: rtl/hdr_reader.sv
// Header RAM read controller: walks the RAM from a descriptor and streams words out.
// Build option HDR_BSWAP_EN byte-reverses each streamed word for big-endian headers.
module hdr_reader
  import hdr_pkg::*;
#(
  parameter int unsigned AW = HDR_AW,
  parameter int unsigned DW = HDR_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hdr_valid,
  output logic          hdr_ready,
  input  logic [AW-1:0] hdr_start,
  input  logic [AW:0]   hdr_len,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          hdr_done,
  output logic          len_err
);

  localparam logic [AW:0] MAX_LEN = (AW+1)'(2**AW);
  localparam logic [AW:0] ONE_LEN = (AW+1)'(1);

  hdr_state_e    state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   remain_q, remain_d;
  logic          hdr_ready_q, hdr_ready_d;
  logic          hdr_done_q, hdr_done_d;
  logic          len_err_q, len_err_d;

  logic          os_valid;
  logic          os_ready_c;
  logic          os_last;
  logic [DW-1:0] os_data;

`ifdef HDR_BSWAP_EN
  always_comb begin
    os_data = '0;
    for (int b = 0; b < int'(DW / 8); b++) begin
      os_data[8*b +: 8] = ram_data[DW-8-8*b +: 8];
    end
  end
`else
  assign os_data = ram_data;
`endif

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remain_d    = remain_q;
    hdr_ready_d = hdr_ready_q;
    hdr_done_d  = 1'b0;
    len_err_d   = 1'b0;
    os_valid    = 1'b0;
    os_last     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hdr_ready_d = 1'b1;
        if (hdr_valid && hdr_ready_q) begin
          if (hdr_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            rd_ptr_d    = hdr_start;
            hdr_ready_d = 1'b0;
            state_d     = ST_STREAM;
            if (hdr_len > MAX_LEN) begin
              len_err_d = 1'b1;
              remain_d  = MAX_LEN;
            end else begin
              remain_d  = hdr_len;
            end
          end
        end
      end
      ST_STREAM: begin
        hdr_ready_d = 1'b0;
        os_valid    = (remain_q != '0);
        os_last     = (remain_q == ONE_LEN);
        if (os_valid && os_ready_c) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          remain_d = remain_q - ONE_LEN;
          if (os_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Ready returns only after the done pulse, so done never overlaps an accept.
        hdr_ready_d = 1'b0;
        if (m_valid && m_ready) begin
          hdr_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        hdr_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      remain_q    <= '0;
      hdr_ready_q <= 1'b0;
      hdr_done_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remain_q    <= remain_d;
      hdr_ready_q <= hdr_ready_d;
      hdr_done_q  <= hdr_done_d;
      len_err_q   <= len_err_d;
    end
  end

  hdr_out_stage #(.DW(DW)) u_out_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (os_valid),
    .in_ready_c (os_ready_c),
    .in_data    (os_data),
    .in_last    (os_last),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  assign ram_addr  = rd_ptr_q;
  assign hdr_ready = hdr_ready_q;
  assign hdr_done  = hdr_done_q;
  assign len_err   = len_err_q;

endmodule
